// File: rtl/imem_loader.sv
// Byte-stream program loader: parses a framed stream (16-bit big-endian
// length, program bytes, checksum byte) and writes the program bytes into
// byte-addressed instruction memory. The core is held in reset until a load
// completes with a good checksum.
module imem_loader #(
  parameter int          MEM_SIZE  = 4095,
  parameter logic [63:0] BASE_ADDR = 64'd0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        in_valid_i,
  input  logic [7:0]  in_data_i,
  output logic        in_ready_o,
  output logic        wr_en_o,
  output logic [63:0] wr_addr_o,
  output logic [7:0]  wr_data_o,
  output logic        core_hold_o,
  output logic        done_o,
  output logic        error_o,
  output logic [15:0] bytes_loaded_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_e;

  // 17 bits so a 16-bit length can always be compared without truncation.
  localparam logic [16:0] MAX_LEN = 17'(MEM_SIZE);

  state_e      state_q, state_d;
  logic        first_q, first_d;   // first cycle in LEN_HI: not ready yet
  logic [15:0] len_q, len_d;
  logic [7:0]  sum_q, sum_d;
  logic [15:0] cnt_q, cnt_d;
  logic        wr_en_q, wr_en_d;
  logic [63:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;

  logic        accept;
  logic [15:0] len_full;

  // Ready in every stream-consuming state, except the settling cycle after
  // entering LEN_HI.
  assign in_ready_o = ((state_q == S_LEN_HI) && !first_q) ||
                      (state_q == S_LEN_LO) || (state_q == S_DATA) ||
                      (state_q == S_CSUM);
  assign accept   = in_valid_i && in_ready_o;
  assign len_full = {len_q[15:8], in_data_i};

  assign wr_en_o        = wr_en_q;
  assign wr_addr_o      = wr_addr_q;
  assign wr_data_o      = wr_data_q;
  assign bytes_loaded_o = cnt_q;
  assign done_o         = (state_q == S_DONE);
  assign error_o        = (state_q == S_ERR);
  assign core_hold_o    = (state_q != S_DONE);

  // Next-state, frame parsing and write generation.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          state_d = S_LEN_HI;
          cnt_d   = '0;
          sum_d   = '0;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d[15:8] = in_data_i;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d[7:0] = in_data_i;
          if (({1'b0, len_full} > MAX_LEN) || (len_full[1:0] != 2'b00))
            state_d = S_ERR;
          else if (len_full == 16'd0)
            state_d = S_CSUM;
          else
            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          sum_d     = sum_q + in_data_i;
          wr_en_d   = 1'b1;
          wr_addr_d = BASE_ADDR + {48'd0, cnt_q};
          wr_data_d = in_data_i;
          cnt_d     = cnt_q + 16'd1;
          if ((cnt_q + 16'd1) == len_q) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (accept) begin
          state_d = (8'(sum_q + in_data_i) == 8'd0) ? S_DONE : S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
    first_d = (state_d == S_LEN_HI) && (state_q != S_LEN_HI);
  end

  // State and output registers; reset wins over start and byte acceptance.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      first_q   <= 1'b0;
      len_q     <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      first_q   <= first_d;
      len_q     <= len_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal, bad checksum, bad length, empty,
// backpressure and mid-load reset scenarios.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, wr_en, core_hold, done, error;
  logic [63:0] wr_addr;
  logic [7:0]  wr_data;
  logic [15:0] bytes_loaded;

  int total = 0;
  int bad   = 0;

  logic [63:0] wa[$];
  logic [7:0]  wd[$];
  logic [7:0]  prog [8] = '{8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93};

  imem_loader #(.MEM_SIZE(4095), .BASE_ADDR(64'd0)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .core_hold_o(core_hold), .done_o(done), .error_o(error),
    .bytes_loaded_o(bytes_loaded)
  );

  always #5 clk = ~clk;

  // Record every write strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    @(posedge clk); #1;
    wa.delete();
    wd.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Present a byte and hold it until the loader takes it.
  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("send_timeout", 64'(n), 64'd0);
    @(posedge clk);
  endtask

  task automatic idle_gap(input int k);
    @(negedge clk); in_valid = 1'b0;
    for (int i = 1; i < k; i++) @(negedge clk);
  endtask

  task automatic stop_stream();
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(done || error) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) chk("end_timeout", 64'(n), 64'd0);
  endtask

  task automatic check_prog(input string tag);
    chk({tag, "_nwr"}, 64'(wa.size()), 64'd8);
    for (int i = 0; i < 8 && i < wa.size(); i++) begin
      chk({tag, "_addr"}, wa[i], 64'(i));
      chk({tag, "_data"}, 64'(wd[i]), 64'(prog[i]));
    end
  endtask

  task automatic frame(input logic [7:0] csum, input logic gaps);
    send(8'h00); send(8'h08);
    for (int i = 0; i < 8; i++) begin
      send(prog[i]);
      if (gaps) idle_gap(int'($urandom_range(1, 5)));
    end
    send(csum);
    stop_stream();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_wren",  64'(wr_en), 64'd0);
    chk("rst_addr",  wr_addr, 64'd0);
    chk("rst_hold",  64'(core_hold), 64'd1);
    chk("rst_done",  64'(done), 64'd0);
    chk("rst_err",   64'(error), 64'd0);
    chk("rst_cnt",   64'(bytes_loaded), 64'd0);
    @(negedge clk); reset = 1'b0;

    // 1: normal load; data sum 0xB6, so checksum 0x4A closes to zero
    clear_log();
    pulse_start();
    chk("s1_ready_settle", 64'(in_ready), 64'd0);
    frame(8'h4A, 1'b0);
    wait_end();
    check_prog("s1");
    chk("s1_done", 64'(done), 64'd1);
    chk("s1_err",  64'(error), 64'd0);
    chk("s1_hold", 64'(core_hold), 64'd0);
    chk("s1_cnt",  64'(bytes_loaded), 64'd8);

    // 2: bad checksum
    clear_log();
    pulse_start();
    chk("s2_done_clr", 64'(done), 64'd0);
    frame(8'h4B, 1'b0);
    wait_end();
    check_prog("s2");
    chk("s2_err",  64'(error), 64'd1);
    chk("s2_done", 64'(done), 64'd0);
    chk("s2_hold", 64'(core_hold), 64'd1);

    // 3: length not a multiple of 4, then length above memory size
    clear_log();
    pulse_start();
    send(8'h00); send(8'h06); stop_stream();
    chk("s3a_err",   64'(error), 64'd1);
    chk("s3a_ready", 64'(in_ready), 64'd0);
    chk("s3a_nwr",   64'(wa.size()), 64'd0);
    pulse_start();
    chk("s3b_err_clr", 64'(error), 64'd0);
    send(8'h10); send(8'h00); stop_stream();
    chk("s3b_err",   64'(error), 64'd1);
    chk("s3b_ready", 64'(in_ready), 64'd0);
    chk("s3b_nwr",   64'(wa.size()), 64'd0);

    // 4: empty program, then reload clears done on the next cycle
    clear_log();
    pulse_start();
    send(8'h00); send(8'h00); send(8'h00); stop_stream();
    chk("s4_done", 64'(done), 64'd1);
    chk("s4_hold", 64'(core_hold), 64'd0);
    chk("s4_nwr",  64'(wa.size()), 64'd0);
    pulse_start();
    chk("s4_done_clr", 64'(done), 64'd0);
    chk("s4_hold_set", 64'(core_hold), 64'd1);
    send(8'h00); send(8'h00); send(8'h00); stop_stream();
    chk("s4_done2", 64'(done), 64'd1);

    // 5: random stalls between bytes give the same writes
    clear_log();
    pulse_start();
    frame(8'h4A, 1'b1);
    wait_end();
    check_prog("s5");
    chk("s5_done", 64'(done), 64'd1);

    // 6: reset after the 3rd data byte, with a 4th byte offered alongside
    clear_log();
    pulse_start();
    send(8'h00); send(8'h08);
    send(prog[0]); send(prog[1]); send(prog[2]);
    @(negedge clk);
    in_valid = 1'b1; in_data = prog[3]; reset = 1'b1;
    @(posedge clk); #1;
    chk("s6_wren",  64'(wr_en), 64'd0);
    chk("s6_ready", 64'(in_ready), 64'd0);
    chk("s6_cnt",   64'(bytes_loaded), 64'd0);
    chk("s6_hold",  64'(core_hold), 64'd1);
    chk("s6_addr",  wr_addr, 64'd0);
    chk("s6_wdata", 64'(wr_data), 64'd0);
    chk("s6_done",  64'(done), 64'd0);
    chk("s6_err",   64'(error), 64'd0);
    chk("s6_nwr",   64'(wa.size()), 64'd3);
    @(negedge clk); reset = 1'b0; in_valid = 1'b0;
    clear_log();
    pulse_start();
    frame(8'h4A, 1'b0);
    wait_end();
    check_prog("s6r");
    chk("s6r_done", 64'(done), 64'd1);
    chk("s6r_cnt",  64'(bytes_loaded), 64'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
